// File: rtl/hyper_mvblck_todram_if.sv
// Bus bundle for hyper_mvblck_todram: LSAB read side, scheduler request
// and MCU collision port. The mover is the master. ABORTED exists only
// when HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN is defined.
interface hyper_mvblck_todram_if;
  logic        LSAB_0_EMPTY;
  logic        LSAB_1_EMPTY;
  logic        LSAB_2_EMPTY;
  logic        LSAB_3_EMPTY;
  logic        LSAB_READ;
  logic [1:0]  LSAB_SECTION;
  logic [11:0] START_ADDRESS;
  logic [4:0]  COUNT_REQ;
  logic [1:0]  SECTION;
  logic        ISSUE;
  logic [4:0]  COUNT_SENT;
  logic        WORKING;
  logic [11:0] MCU_COLL_ADDRESS;
  logic        MCU_REQUEST_ACCESS;
  logic        MCU_WRITE_MASK;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
  logic        ABORTED;
`endif

  modport master (
    input  LSAB_0_EMPTY, LSAB_1_EMPTY, LSAB_2_EMPTY, LSAB_3_EMPTY,
    input  START_ADDRESS, COUNT_REQ, SECTION, ISSUE,
    output LSAB_READ, LSAB_SECTION, COUNT_SENT, WORKING,
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
    output ABORTED,
`endif
    output MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS, MCU_WRITE_MASK
  );

  modport slave (
    output LSAB_0_EMPTY, LSAB_1_EMPTY, LSAB_2_EMPTY, LSAB_3_EMPTY,
    output START_ADDRESS, COUNT_REQ, SECTION, ISSUE,
    input  LSAB_READ, LSAB_SECTION, COUNT_SENT, WORKING,
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
    input  ABORTED,
`endif
    input  MCU_COLL_ADDRESS, MCU_REQUEST_ACCESS, MCU_WRITE_MASK
  );
endinterface

// File: rtl/hyper_mvblck_todram.sv
// hyper_mvblck_todram: LSAB-to-DRAM block mover. Issues aligned DRAM slot
// pairs on the MCU collision port, pops LSAB words so they arrive with the
// slot data phase, and masks padding slots at unaligned block edges.
// Optional macro HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN adds the ABORTED flag.
module hyper_mvblck_todram #(
  parameter int unsigned LSAB_RD_LAT = 1,
  parameter int unsigned MCU_WR_LAT  = 2
) (
  input logic                   CLK,
  input logic                   RST,
  hyper_mvblck_todram_if.master bus
);
  localparam int unsigned RD_STG = MCU_WR_LAT - LSAB_RD_LAT;

  typedef enum logic [1:0] {IDLE, ISSUE_RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [1:0]            section_q, section_d;
  logic [11:0]           addr_q, addr_d;
  logic [5:0]            slots_q, slots_d;
  logic [5:0]            last_q, last_d;
  logic [5:0]            k_q, k_d;
  logic                  first_q, first_d;
  logic [4:0]            count_sent_q, count_sent_d;
  logic                  working_q, working_d;
  // Slot-tag pipelines: stage j holds the slot presented j cycles ago.
  logic [MCU_WR_LAT-1:0] vld_q, vld_d;
  logic [RD_STG:0]       rd_q, rd_d;
  logic [MCU_WR_LAT:0]   pad_q, pad_d;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
  logic                  abort_pend_q, abort_pend_d;
  logic                  aborted_q, aborted_d;
`endif

  logic [3:0] empty_vec;
  logic [5:0] slots_new, last_new;
  logic       slot_go, slot_useful;
  logic [5:0] slot_k;

  assign empty_vec = {bus.LSAB_3_EMPTY, bus.LSAB_2_EMPTY, bus.LSAB_1_EMPTY, bus.LSAB_0_EMPTY};
  assign slots_new = ({1'b0, bus.COUNT_REQ} + {5'b0, bus.START_ADDRESS[0]} + 6'd1) & 6'b111110;
  assign last_new  = {1'b0, bus.COUNT_REQ} + {5'b0, bus.START_ADDRESS[0]} - 6'd1;

  // Next-state: acceptance, pair-boundary empty checks, drain and slot pipelines.
  always_comb begin
    state_d      = state_q;
    section_d    = section_q;
    addr_d       = addr_q;
    slots_d      = slots_q;
    last_d       = last_q;
    k_d          = k_q;
    first_d      = first_q;
    working_d    = working_q;
    count_sent_d = count_sent_q + {4'b0, rd_q[RD_STG]};
    slot_go      = 1'b0;
    slot_k       = k_q;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.ISSUE && (bus.COUNT_REQ != 5'd0)) begin
          section_d    = bus.SECTION;
          addr_d       = {bus.START_ADDRESS[11:1], 1'b0};
          slots_d      = slots_new;
          last_d       = last_new;
          first_d      = bus.START_ADDRESS[0];
          count_sent_d = '0;
          working_d    = 1'b1;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
`endif
          if (empty_vec[bus.SECTION]) begin
            state_d = DRAIN;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
            abort_pend_d = 1'b1;
`endif
          end else begin
            slot_go = 1'b1;
            slot_k  = '0;
            k_d     = 6'd1;
            state_d = ISSUE_RUN;
          end
        end
      end
      ISSUE_RUN: begin
        if (k_q == slots_q) begin
          state_d = DRAIN;
        end else if (!k_q[0] && empty_vec[section_q]) begin
          state_d = DRAIN;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
          abort_pend_d = (k_q <= last_q);
`endif
        end else begin
          slot_go = 1'b1;
          k_d     = k_q + 6'd1;
          addr_d  = addr_q + 12'd1;
        end
      end
      DRAIN: begin
        if (vld_q == '0) begin
          working_d = 1'b0;
          state_d   = IDLE;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
          aborted_d = abort_pend_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // first_d/last_d so the acceptance slot uses the freshly latched bounds.
    slot_useful = slot_go && (slot_k >= {5'b0, first_d}) && (slot_k <= last_d);

    vld_d[0] = slot_go;
    for (int unsigned j = 1; j < MCU_WR_LAT; j++) vld_d[j] = vld_q[j-1];
    rd_d[0] = slot_useful;
    for (int unsigned j = 1; j <= RD_STG; j++) rd_d[j] = rd_q[j-1];
    pad_d[0] = slot_go && !slot_useful;
    for (int unsigned j = 1; j <= MCU_WR_LAT; j++) pad_d[j] = pad_q[j-1];
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      section_q    <= '0;
      addr_q       <= '0;
      slots_q      <= '0;
      last_q       <= '0;
      k_q          <= '0;
      first_q      <= 1'b0;
      count_sent_q <= '0;
      working_q    <= 1'b0;
      vld_q        <= '0;
      rd_q         <= '0;
      pad_q        <= '0;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      section_q    <= section_d;
      addr_q       <= addr_d;
      slots_q      <= slots_d;
      last_q       <= last_d;
      k_q          <= k_d;
      first_q      <= first_d;
      count_sent_q <= count_sent_d;
      working_q    <= working_d;
      vld_q        <= vld_d;
      rd_q         <= rd_d;
      pad_q        <= pad_d;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
`endif
    end
  end

  assign bus.LSAB_READ          = rd_q[RD_STG];
  assign bus.LSAB_SECTION       = section_q;
  assign bus.COUNT_SENT         = count_sent_q;
  assign bus.WORKING            = working_q;
  assign bus.MCU_COLL_ADDRESS   = addr_q;
  assign bus.MCU_REQUEST_ACCESS = vld_q[0];
  assign bus.MCU_WRITE_MASK     = pad_q[MCU_WR_LAT];
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
  assign bus.ABORTED            = aborted_q;
`endif
endmodule

// File: tb/tb_hyper_mvblck_todram.sv
// Directed self-checking bench for hyper_mvblck_todram (LSAB_RD_LAT=1,
// MCU_WR_LAT=2). Per-cycle outputs are captured as bit vectors indexed by
// cycle number (cycle 1 = the cycle after the accepting edge).
module tb_hyper_mvblck_todram;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hyper_mvblck_todram_if bus_if();

  hyper_mvblck_todram #(.LSAB_RD_LAT(1), .MCU_WR_LAT(2)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] cap_req, cap_rd, cap_msk, cap_wrk;
  logic [11:0] cap_addr [0:31];

  task automatic start_xfer(input logic [11:0] sa, input logic [4:0] cnt, input logic [1:0] sec);
    @(negedge clk);
    bus_if.START_ADDRESS = sa;
    bus_if.COUNT_REQ     = cnt;
    bus_if.SECTION       = sec;
    bus_if.ISSUE         = 1'b1;
    @(posedge clk);
    #1;
    bus_if.ISSUE = 1'b0;
  endtask

  // ev_kind 1: raise LSAB_0_EMPTY in ev_cycle; 2: pulse ISSUE with a different request.
  task automatic capture(input int ncyc, input int ev_cycle, input int ev_kind);
    cap_req = '0; cap_rd = '0; cap_msk = '0; cap_wrk = '0;
    for (int n = 1; n <= ncyc; n++) begin
      cap_req[n]  = bus_if.MCU_REQUEST_ACCESS;
      cap_rd[n]   = bus_if.LSAB_READ;
      cap_msk[n]  = bus_if.MCU_WRITE_MASK;
      cap_wrk[n]  = bus_if.WORKING;
      cap_addr[n] = bus_if.MCU_COLL_ADDRESS;
      if (n == ev_cycle && ev_kind == 1) bus_if.LSAB_0_EMPTY = 1'b1;
      if (n == ev_cycle && ev_kind == 2) begin
        bus_if.ISSUE = 1'b1; bus_if.START_ADDRESS = 12'h300;
        bus_if.COUNT_REQ = 5'd6; bus_if.SECTION = 2'd1;
      end
      if (n == ev_cycle + 1 && ev_kind == 2) bus_if.ISSUE = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({bus_if.WORKING, bus_if.MCU_REQUEST_ACCESS, bus_if.LSAB_READ, bus_if.MCU_WRITE_MASK,
         bus_if.COUNT_SENT, bus_if.MCU_COLL_ADDRESS, bus_if.LSAB_SECTION} !== 22'h0)
      $display("FAIL reset_outputs: got work=%b req=%b rd=%b msk=%b cnt=%h addr=%h sec=%h required all 0",
               bus_if.WORKING, bus_if.MCU_REQUEST_ACCESS, bus_if.LSAB_READ, bus_if.MCU_WRITE_MASK,
               bus_if.COUNT_SENT, bus_if.MCU_COLL_ADDRESS, bus_if.LSAB_SECTION);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_aligned();
    start_xfer(12'h010, 5'd4, 2'd2);
    capture(10, 0, 0);
    n_checks++; if (cap_req !== 32'h1E) $display("FAIL aligned_req: got %h required %h", cap_req, 32'h1E); else n_pass++;
    n_checks++; if (cap_rd  !== 32'h3C) $display("FAIL aligned_read: got %h required %h", cap_rd, 32'h3C); else n_pass++;
    n_checks++; if (cap_msk !== 32'h00) $display("FAIL aligned_mask: got %h required %h", cap_msk, 32'h00); else n_pass++;
    n_checks++; if (cap_wrk !== 32'h7E) $display("FAIL aligned_working: got %h required %h", cap_wrk, 32'h7E); else n_pass++;
    for (int n = 1; n <= 4; n++) begin
      n_checks++;
      if (cap_addr[n] !== 12'h010 + 12'(n - 1))
        $display("FAIL aligned_addr_c%0d: got %h required %h", n, cap_addr[n], 12'h010 + 12'(n - 1));
      else n_pass++;
    end
    n_checks++; if (bus_if.COUNT_SENT !== 5'd4) $display("FAIL aligned_count: got %0d required 4", bus_if.COUNT_SENT); else n_pass++;
    n_checks++; if (bus_if.LSAB_SECTION !== 2'd2) $display("FAIL aligned_section: got %0d required 2", bus_if.LSAB_SECTION); else n_pass++;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
    n_checks++; if (bus_if.ABORTED !== 1'b0) $display("FAIL aligned_aborted: got %b required 0", bus_if.ABORTED); else n_pass++;
`endif
  endtask

  task automatic test_unaligned();
    start_xfer(12'h011, 5'd4, 2'd1);
    capture(12, 0, 0);
    n_checks++; if (cap_req !== 32'h7E)  $display("FAIL unaligned_req: got %h required %h", cap_req, 32'h7E); else n_pass++;
    n_checks++; if (cap_rd  !== 32'h78)  $display("FAIL unaligned_read: got %h required %h", cap_rd, 32'h78); else n_pass++;
    n_checks++; if (cap_msk !== 32'h108) $display("FAIL unaligned_mask: got %h required %h", cap_msk, 32'h108); else n_pass++;
    n_checks++; if (cap_wrk !== 32'h1FE) $display("FAIL unaligned_working: got %h required %h", cap_wrk, 32'h1FE); else n_pass++;
    for (int n = 1; n <= 6; n++) begin
      n_checks++;
      if (cap_addr[n] !== 12'h010 + 12'(n - 1))
        $display("FAIL unaligned_addr_c%0d: got %h required %h", n, cap_addr[n], 12'h010 + 12'(n - 1));
      else n_pass++;
    end
    n_checks++; if (bus_if.COUNT_SENT !== 5'd4) $display("FAIL unaligned_count: got %0d required 4", bus_if.COUNT_SENT); else n_pass++;
  endtask

  task automatic test_early_stop();
    start_xfer(12'h020, 5'd8, 2'd0);
    capture(12, 3, 1);
    bus_if.LSAB_0_EMPTY = 1'b0;
    n_checks++; if (cap_req !== 32'h1E) $display("FAIL early_req: got %h required %h", cap_req, 32'h1E); else n_pass++;
    n_checks++; if (cap_rd  !== 32'h3C) $display("FAIL early_read: got %h required %h", cap_rd, 32'h3C); else n_pass++;
    n_checks++; if (cap_wrk !== 32'h7E) $display("FAIL early_working: got %h required %h", cap_wrk, 32'h7E); else n_pass++;
    n_checks++; if (cap_addr[4] !== 12'h023) $display("FAIL early_addr_c4: got %h required 023", cap_addr[4]); else n_pass++;
    n_checks++; if (bus_if.COUNT_SENT !== 5'd4) $display("FAIL early_count: got %0d required 4", bus_if.COUNT_SENT); else n_pass++;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
    n_checks++; if (bus_if.ABORTED !== 1'b1) $display("FAIL early_aborted: got %b required 1", bus_if.ABORTED); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr [1:4];
    exp_addr[1] = 12'hFFE; exp_addr[2] = 12'hFFF; exp_addr[3] = 12'h000; exp_addr[4] = 12'h001;
    start_xfer(12'hFFF, 5'd2, 2'd3);
    capture(10, 0, 0);
    n_checks++; if (cap_req !== 32'h1E) $display("FAIL wrap_req: got %h required %h", cap_req, 32'h1E); else n_pass++;
    n_checks++; if (cap_rd  !== 32'h18) $display("FAIL wrap_read: got %h required %h", cap_rd, 32'h18); else n_pass++;
    n_checks++; if (cap_msk !== 32'h48) $display("FAIL wrap_mask: got %h required %h", cap_msk, 32'h48); else n_pass++;
    for (int n = 1; n <= 4; n++) begin
      n_checks++;
      if (cap_addr[n] !== exp_addr[n])
        $display("FAIL wrap_addr_c%0d: got %h required %h", n, cap_addr[n], exp_addr[n]);
      else n_pass++;
    end
    n_checks++; if (bus_if.COUNT_SENT !== 5'd2) $display("FAIL wrap_count: got %0d required 2", bus_if.COUNT_SENT); else n_pass++;
  endtask

  task automatic test_count_zero();
    start_xfer(12'h050, 5'd0, 2'd1);
    capture(6, 0, 0);
    n_checks++; if (cap_req !== 32'h0) $display("FAIL zero_req: got %h required 0", cap_req); else n_pass++;
    n_checks++; if (cap_wrk !== 32'h0) $display("FAIL zero_working: got %h required 0", cap_wrk); else n_pass++;
    n_checks++; if (bus_if.COUNT_SENT !== 5'd2) $display("FAIL zero_count_hold: got %0d required 2", bus_if.COUNT_SENT); else n_pass++;
    n_checks++; if (bus_if.LSAB_SECTION !== 2'd3) $display("FAIL zero_section_hold: got %0d required 3", bus_if.LSAB_SECTION); else n_pass++;
  endtask

  task automatic test_issue_busy();
    start_xfer(12'h010, 5'd4, 2'd2);
    capture(14, 2, 2);
    n_checks++; if (cap_req !== 32'h1E) $display("FAIL busy_req: got %h required %h", cap_req, 32'h1E); else n_pass++;
    n_checks++; if (cap_wrk !== 32'h7E) $display("FAIL busy_working: got %h required %h", cap_wrk, 32'h7E); else n_pass++;
    n_checks++; if (bus_if.COUNT_SENT !== 5'd4) $display("FAIL busy_count: got %0d required 4", bus_if.COUNT_SENT); else n_pass++;
    n_checks++; if (bus_if.LSAB_SECTION !== 2'd2) $display("FAIL busy_section: got %0d required 2", bus_if.LSAB_SECTION); else n_pass++;
  endtask

  task automatic test_empty_at_accept();
    bus_if.LSAB_1_EMPTY = 1'b1;
    start_xfer(12'h040, 5'd3, 2'd1);
    capture(6, 0, 0);
    bus_if.LSAB_1_EMPTY = 1'b0;
    n_checks++; if (cap_req !== 32'h0) $display("FAIL eacc_req: got %h required 0", cap_req); else n_pass++;
    n_checks++; if (cap_rd  !== 32'h0) $display("FAIL eacc_read: got %h required 0", cap_rd); else n_pass++;
    n_checks++; if (cap_wrk !== 32'h2) $display("FAIL eacc_working: got %h required 2", cap_wrk); else n_pass++;
    n_checks++; if (bus_if.COUNT_SENT !== 5'd0) $display("FAIL eacc_count: got %0d required 0", bus_if.COUNT_SENT); else n_pass++;
`ifdef HYPER_MVBLCK_TODRAM_ABORT_FLAG_EN
    n_checks++; if (bus_if.ABORTED !== 1'b1) $display("FAIL eacc_aborted: got %b required 1", bus_if.ABORTED); else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    start_xfer(12'h080, 5'd16, 2'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus_if.MCU_COLL_ADDRESS !== 12'h082) $display("FAIL ares_pre_addr: got %h required 082", bus_if.MCU_COLL_ADDRESS); else n_pass++;
    n_checks++; if (bus_if.LSAB_READ !== 1'b1) $display("FAIL ares_pre_read: got %b required 1", bus_if.LSAB_READ); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_if.WORKING !== 1'b0) $display("FAIL ares_working: got %b required 0", bus_if.WORKING); else n_pass++;
    n_checks++; if (bus_if.MCU_REQUEST_ACCESS !== 1'b0) $display("FAIL ares_req: got %b required 0", bus_if.MCU_REQUEST_ACCESS); else n_pass++;
    n_checks++; if (bus_if.LSAB_READ !== 1'b0) $display("FAIL ares_read: got %b required 0", bus_if.LSAB_READ); else n_pass++;
    n_checks++; if (bus_if.MCU_COLL_ADDRESS !== 12'h000) $display("FAIL ares_addr: got %h required 000", bus_if.MCU_COLL_ADDRESS); else n_pass++;
    n_checks++; if (bus_if.COUNT_SENT !== 5'd0) $display("FAIL ares_count: got %0d required 0", bus_if.COUNT_SENT); else n_pass++;
    n_checks++; if (bus_if.LSAB_SECTION !== 2'd0) $display("FAIL ares_section: got %0d required 0", bus_if.LSAB_SECTION); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    start_xfer(12'h010, 5'd4, 2'd2);
    capture(10, 0, 0);
    n_checks++; if (cap_req !== 32'h1E) $display("FAIL ares_after_req: got %h required %h", cap_req, 32'h1E); else n_pass++;
    n_checks++; if (cap_rd  !== 32'h3C) $display("FAIL ares_after_read: got %h required %h", cap_rd, 32'h3C); else n_pass++;
    n_checks++; if (bus_if.COUNT_SENT !== 5'd4) $display("FAIL ares_after_count: got %0d required 4", bus_if.COUNT_SENT); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.LSAB_0_EMPTY = 1'b0; bus_if.LSAB_1_EMPTY = 1'b0;
    bus_if.LSAB_2_EMPTY = 1'b0; bus_if.LSAB_3_EMPTY = 1'b0;
    bus_if.START_ADDRESS = '0; bus_if.COUNT_REQ = '0;
    bus_if.SECTION = '0; bus_if.ISSUE = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_early_stop();
    test_wrap();
    test_count_zero();
    test_issue_busy();
    test_empty_at_accept();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
